ofdm_demapper: RTL and testbench
================================

# ofdm_demapper

Downstream stage of the channel estimator/equalizer. Once that stage reports its output buffer full, this block reads every equalized sample out of it through the read-pointer port. It hard-decision demaps each sample (QPSK, or 16-QAM when compiled in) and packs the bits into a byte stream with valid/ready backpressure. After the last byte is accepted, it pulses `eq_tx_done` to release the upstream buffers for the next burst.

## Interface
Parameters:
- `ACTIVE_SUBCARR`, 28: active subcarriers per OFDM symbol.
- `SYMBOL_NUM`, 8: data symbols per burst.
- `READ_LATENCY`, 3: clock edges from an `eq_read_ptr` update until `eq_dout` holds that address's data.
- `QAM_THRESH`, 8'sd40: 16-QAM inner/outer decision magnitude (used only with the macro).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `eq_buff_full` in 1: upstream output buffer holds a complete burst.
- `eq_dout` in 16: equalized sample, `{im[7:0], re[7:0]}`, signed two's complement.
- `eq_read_ptr` out 8: upstream read address, registered.
- `eq_tx_done` out 1: one-cycle pulse; the burst has been consumed and upstream must reset.
- `m_data` out 8: demapped byte.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: sink accepts the byte.
- `m_last` out 1: marks the final byte of the burst, qualified by `m_valid`.
- `busy` out 1: high from leaving IDLE until returning to IDLE.

## Operation
- N = `ACTIVE_SUBCARR*SYMBOL_NUM` samples per burst (224 at default). Addresses run 0..N-1 in order.
- States and transitions:
  - IDLE: on `eq_buff_full`=1, set ptr=0 and go to ADDR.
  - ADDR: drive `eq_read_ptr`=ptr, then go to WAIT.
  - WAIT: count `READ_LATENCY` edges, then go to CAPTURE.
  - CAPTURE: sample `eq_dout`, demap, and shift the bits into the byte register. If the byte is complete, go to EMIT. Otherwise increment ptr and go to ADDR.
  - EMIT: hold `m_valid` until `m_ready`. Once accepted, go to DONE if ptr==N-1; otherwise increment ptr and go to ADDR.
  - DONE: pulse `eq_tx_done` for one cycle, then go to WAIT_CLR.
  - WAIT_CLR: wait for `eq_buff_full`=0, then go to IDLE.
- QPSK decisions: b_re = (re<0), b_im = (im<0). Each sample contributes 2 bits `{b_im,b_re}`. Bits pack LSB-first, so sample k of a byte occupies bits [2k+1:2k]. Result: 4 samples per byte, 56 bytes per burst.
- Outputs are never mid-update while `m_valid`=1: `m_data` and `m_last` stay stable until the handshake completes.
- If `eq_buff_full` deasserts mid-burst, it is ignored and the burst completes.
- If `eq_buff_full` is still high in WAIT_CLR, the block stays there and does not restart on the same burst.
- If `rst_n` asserts mid-burst, all state and outputs clear immediately. No `eq_tx_done` is issued, and the partial byte is discarded.
- `m_ready` high while `m_valid` is low has no effect.

## Timing
- Reset values: `eq_read_ptr`=0, `m_data`=0, `m_valid`=0, `m_last`=0, `eq_tx_done`=0, `busy`=0. The FSM is in IDLE.
- Per sample: ADDR(1) + WAIT(`READ_LATENCY`) + CAPTURE(1) = 5 cycles at default.
- `eq_dout` is sampled at the edge `READ_LATENCY`+1 edges after the edge that loaded `eq_read_ptr`.
- The first `m_valid` rises 4×5 = 20 cycles after IDLE exits (QPSK), assuming no stall.
- EMIT lasts at least 1 cycle and waits indefinitely on `m_ready`=0. The byte is accepted on the edge where `m_valid`&`m_ready`=1.
- `eq_tx_done` rises 2 edges after the final handshake: one edge into DONE, one edge to register the pulse. It stays high for exactly 1 cycle.

## Configuration
- `DEMAP_16QAM_EN` defined: 16-QAM demapping.
  - Per axis x ∈ {re, im}: bit0 = (x<0); bit1 = (x > -`QAM_THRESH` && x < `QAM_THRESH`), i.e. 1 means inner point.
  - Each sample gives 4 bits `{im_b1, im_b0, re_b1, re_b0}`.
  - Result: 2 samples per byte, 112 bytes per burst.
  - The comparison is done at 9-bit signed width, so -128 is classified outer without overflow.
- `DEMAP_16QAM_EN` undefined: QPSK only. The threshold logic is absent and `QAM_THRESH` is unused.

## Structure
- Shared package `ofdm_pkg`:
  - constants `ACTIVE_SUBCARR`, `SYMBOL_NUM`;
  - derived `BURST_SAMPLES`;
  - `BITS_PER_SAMPLE` and `BYTES_PER_BURST`, selected by the macro;
  - FSM state enum `demap_state_t`.
- One sub-module, `demap_slicer`: combinational `eq_dout` → 2- or 4-bit decision. All sequencing stays in the top level.

## Test plan
- Burst of 224 samples with re=+20, im=-20 for every sample (QPSK) -> 56 bytes, each 8'hAA. `m_last` is high only on byte 56, then one `eq_tx_done` pulse.
- Ramp addresses through a model with 3-edge latency, data = {~ptr, ptr} -> `eq_read_ptr` steps 0..223 with 5 cycles per step. Captured signs match the model for every address.
- `m_ready` low for 10 cycles on byte 3 -> `m_data` and `m_valid` hold, `eq_read_ptr` freezes, and no sample is lost.
- `rst_n` low at sample 100 -> all outputs 0 immediately and no `eq_tx_done`. The next `eq_buff_full` restarts at ptr 0.
- `eq_buff_full` held high 50 cycles after `eq_tx_done` -> stays in WAIT_CLR. IDLE restarts only on the next rising burst-full.
- `DEMAP_16QAM_EN`, samples (re,im) = (-128, 39), (40, -39) with `QAM_THRESH`=40 -> nibbles 4'b1001 and 4'b1100 respectively, packed into byte 8'hC9. The burst yields 112 bytes.

Source files
------------

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared constants, derived burst sizes and the demapper FSM state type.
// Build option: DEMAP_16QAM_EN selects 16-QAM (4 bits/sample) instead of QPSK (2 bits/sample).
package ofdm_pkg;

  localparam int unsigned ACTIVE_SUBCARR = 28;
  localparam int unsigned SYMBOL_NUM     = 8;
  localparam int unsigned BURST_SAMPLES  = ACTIVE_SUBCARR * SYMBOL_NUM;

`ifdef DEMAP_16QAM_EN
  localparam int unsigned BITS_PER_SAMPLE = 4;
`else
  localparam int unsigned BITS_PER_SAMPLE = 2;
`endif

  localparam int unsigned BYTES_PER_BURST = BURST_SAMPLES * BITS_PER_SAMPLE / 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StCapture,
    StEmit,
    StDone,
    StWaitClr
  } demap_state_t;

endpackage

// File: rtl/ofdm_demapper_if.sv
// ofdm_demapper_if: groups the equalizer read port, the byte stream and the status lines.
//   master modport: demapper side (drives read pointer, byte stream, done pulse, busy).
//   slave modport : environment side (drives buffer-full, equalized sample, sink ready).
interface ofdm_demapper_if;

  logic        eq_buff_full;
  logic [15:0] eq_dout;
  logic [7:0]  eq_read_ptr;
  logic        eq_tx_done;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;

  modport master (
    input  eq_buff_full,
    input  eq_dout,
    input  m_ready,
    output eq_read_ptr,
    output eq_tx_done,
    output m_data,
    output m_valid,
    output m_last,
    output busy
  );

  modport slave (
    output eq_buff_full,
    output eq_dout,
    output m_ready,
    input  eq_read_ptr,
    input  eq_tx_done,
    input  m_data,
    input  m_valid,
    input  m_last,
    input  busy
  );

endinterface

// File: rtl/demap_slicer.sv
// demap_slicer: combinational hard decision of one equalized sample {im[7:0], re[7:0]}.
//   eq_dout_i : signed sample pair
//   bits_o    : QPSK {b_im, b_re}, or with DEMAP_16QAM_EN {im_b1, im_b0, re_b1, re_b0}
//               where b0 = sign and b1 = inner-point flag (|x| < QAM_THRESH).
module demap_slicer
  import ofdm_pkg::*;
`ifdef DEMAP_16QAM_EN
#(
  parameter logic signed [7:0] QAM_THRESH = 8'sd40
)
`endif
(
  input  logic [15:0]                eq_dout_i,
  output logic [BITS_PER_SAMPLE-1:0] bits_o
);

`ifdef DEMAP_16QAM_EN
  logic signed [8:0] re_w, im_w, thr_w;

  // Widen to 9 bits so negating the threshold and comparing -128 cannot overflow.
  assign re_w  = {eq_dout_i[7], eq_dout_i[7:0]};
  assign im_w  = {eq_dout_i[15], eq_dout_i[15:8]};
  assign thr_w = {QAM_THRESH[7], QAM_THRESH};

  function automatic logic is_inner(input logic signed [8:0] x, input logic signed [8:0] t);
    return (x > -t) && (x < t);
  endfunction

  assign bits_o = {is_inner(im_w, thr_w), eq_dout_i[15], is_inner(re_w, thr_w), eq_dout_i[7]};
`else
  logic unused_mag;

  // QPSK needs only the sign bits.
  assign unused_mag = ^{eq_dout_i[14:8], eq_dout_i[6:0]};
  assign bits_o     = {eq_dout_i[15], eq_dout_i[7]};
`endif

endmodule

// File: rtl/ofdm_demapper.sv
// ofdm_demapper: reads a complete equalized burst through a latency-READ_LATENCY read port,
// hard-decision demaps each sample and streams packed bytes (LSB-first) with valid/ready.
// After the last byte is accepted it pulses eq_tx_done and waits for eq_buff_full to drop.
// Build option: DEMAP_16QAM_EN enables 16-QAM decisions (QAM_THRESH), otherwise QPSK.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus.eq_buff_full   : upstream burst ready        bus.eq_dout    : sample at read address
//   bus.eq_read_ptr    : registered read address     bus.eq_tx_done : one-cycle release pulse
//   bus.m_data/m_valid/m_ready/m_last : byte stream  bus.busy       : not in IDLE
module ofdm_demapper
  import ofdm_pkg::*;
#(
  parameter int unsigned ACTIVE_SUBCARR = 28,
  parameter int unsigned SYMBOL_NUM     = 8,
  parameter int unsigned READ_LATENCY   = 3
`ifdef DEMAP_16QAM_EN
  ,
  parameter logic signed [7:0] QAM_THRESH = 8'sd40
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  ofdm_demapper_if.master bus
);

  localparam int unsigned NSamp       = ACTIVE_SUBCARR * SYMBOL_NUM;
  localparam int unsigned SampPerByte = 8 / BITS_PER_SAMPLE;
  localparam int unsigned AccW        = 8 - BITS_PER_SAMPLE;
  localparam logic [7:0]  LastPtr     = 8'(NSamp - 1);
  localparam logic [7:0]  LastWait    = 8'(READ_LATENCY - 1);
  localparam logic [1:0]  LastSamp    = 2'(SampPerByte - 1);

  demap_state_t              state_q;
  logic [7:0]                ptr_q;
  logic [7:0]                rd_ptr_q;
  logic [7:0]                wait_cnt_q;
  logic [1:0]                samp_cnt_q;
  logic [AccW-1:0]           acc_q;
  logic [7:0]                m_data_q;
  logic                      m_valid_q;
  logic                      m_last_q;
  logic                      tx_done_q;
  logic                      busy_q;
  logic [BITS_PER_SAMPLE-1:0] bits;
  logic [7:0]                byte_next;

`ifdef DEMAP_16QAM_EN
  demap_slicer #(
    .QAM_THRESH (QAM_THRESH)
  ) u_slicer (
    .eq_dout_i (bus.eq_dout),
    .bits_o    (bits)
  );
`else
  demap_slicer u_slicer (
    .eq_dout_i (bus.eq_dout),
    .bits_o    (bits)
  );
`endif

  // acc_q holds the earlier samples of the current byte; the newest sample lands on top so
  // that after a full byte sample k sits at bits [k*BITS_PER_SAMPLE +: BITS_PER_SAMPLE].
  always_comb begin
    byte_next = {bits, acc_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rd_ptr_q   <= '0;
      wait_cnt_q <= '0;
      samp_cnt_q <= '0;
      acc_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.eq_buff_full) begin
            ptr_q      <= '0;
            samp_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          rd_ptr_q   <= ptr_q;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == LastWait) begin
            state_q <= StCapture;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StCapture: begin
          acc_q <= byte_next[7:BITS_PER_SAMPLE];
          if (samp_cnt_q == LastSamp) begin
            samp_cnt_q <= '0;
            m_data_q   <= byte_next;
            m_valid_q  <= 1'b1;
            m_last_q   <= (ptr_q == LastPtr);
            state_q    <= StEmit;
          end else begin
            samp_cnt_q <= samp_cnt_q + 2'd1;
            ptr_q      <= ptr_q + 8'd1;
            state_q    <= StAddr;
          end
        end
        StEmit: begin
          // m_data_q/m_last_q are untouched here until the handshake completes.
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (ptr_q == LastPtr) begin
              state_q <= StDone;
            end else begin
              ptr_q   <= ptr_q + 8'd1;
              state_q <= StAddr;
            end
          end
        end
        StDone: begin
          tx_done_q <= 1'b1;
          state_q   <= StWaitClr;
        end
        StWaitClr: begin
          // Require buff_full to drop so the same burst is never consumed twice.
          if (!bus.eq_buff_full) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.eq_read_ptr = rd_ptr_q;
  assign bus.eq_tx_done  = tx_done_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_last      = m_last_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ofdm_demapper.sv
// tb_ofdm_demapper: directed bursts against a sample-memory model of the equalizer with a
// three-edge read latency; expected bytes come from per-sample sign/magnitude rules.
`timescale 1ns/1ps
module tb_ofdm_demapper;

  localparam int N = 224;
`ifdef DEMAP_16QAM_EN
  localparam int Bps = 4;
`else
  localparam int Bps = 2;
`endif
  localparam int Spb = 8 / Bps;
  localparam int Nb  = N / Spb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_demapper_if bus_if ();

  ofdm_demapper u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Upstream buffer: data for an address appears three edges after the address is loaded.
  logic [15:0] mem [N];
  logic [7:0]  p1 = 8'd0;
  logic [7:0]  p2 = 8'd0;
  always @(posedge clk) begin
    p1            <= bus_if.eq_read_ptr;
    p2            <= p1;
    bus_if.eq_dout <= mem[p2];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Decision bits of one sample from the signed re/im values.
  function automatic logic [3:0] slice(input logic [15:0] d);
    int re, im;
    logic [3:0] r;
    re = int'($signed(d[7:0]));
    im = int'($signed(d[15:8]));
    r  = 4'd0;
`ifdef DEMAP_16QAM_EN
    r[0] = (re < 0);
    r[1] = (re > -40) && (re < 40);
    r[2] = (im < 0);
    r[3] = (im > -40) && (im < 40);
`else
    r[0] = (re < 0);
    r[1] = (im < 0);
`endif
    return r;
  endfunction

  logic [7:0] exp_b [Nb];

  task automatic build_exp();
    logic [7:0] b;
    for (int j = 0; j < Nb; j++) begin
      b = 8'd0;
      for (int k = 0; k < Spb; k++) b = b | (8'(slice(mem[j*Spb+k])) << (k*Bps));
      exp_b[j] = b;
    end
  endtask

  bit         chk_en = 1'b0;
  bit         stall_en = 1'b0;
  int         stall_cyc = 0;
  int         stall_checks = 0;
  int         hs_idx = 0;
  int         tx_cnt = 0;
  int         tx_any = 0;
  int         since_last = -1;
  int         rp_cyc = 0;
  int         rp_vcyc = 0;
  logic [7:0] first_byte = 8'd0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] prev_ptr = 8'd0;
  logic [7:0] prev_rp = 8'd0;
  logic       prev_last = 1'b0;
  logic       prev_stall = 1'b0;

  // Single compare process, sampling at the falling edge.
  always @(negedge clk) begin
    rp_cyc++;
    if (bus_if.m_valid) rp_vcyc++;
    if (bus_if.eq_tx_done) tx_any++;
    if (chk_en && rst_n) begin
      if (prev_stall) begin
        chk("hold_data", bus_if.m_data, prev_data);
        chk("hold_last", bus_if.m_last, prev_last);
        chk("hold_valid", bus_if.m_valid, 1);
        chk("hold_ptr", bus_if.eq_read_ptr, prev_ptr);
        stall_checks++;
      end
      if (bus_if.eq_read_ptr !== prev_rp && bus_if.eq_read_ptr != 8'd0) begin
        chk("ptr_step", bus_if.eq_read_ptr, prev_rp + 8'd1);
        if (prev_rp != 8'd0) chk("ptr_interval", rp_cyc, 5 + rp_vcyc);
      end
      if (since_last >= 0) since_last++;
      if (bus_if.eq_tx_done) begin
        tx_cnt++;
        chk("tx_done_timing", since_last, 2);
      end
      if (since_last > 4) since_last = -1;
      if (bus_if.m_valid && bus_if.m_ready) begin
        if (hs_idx >= Nb) begin
          chk("extra_byte", hs_idx, Nb - 1);
        end else begin
          chk("byte_data", bus_if.m_data, exp_b[hs_idx]);
          chk("byte_last", bus_if.m_last, (hs_idx == Nb - 1));
        end
        if (hs_idx == 0) first_byte = bus_if.m_data;
        if (hs_idx == Nb - 1) since_last = 0;
        hs_idx++;
      end
    end
    if (bus_if.eq_read_ptr !== prev_rp) begin
      rp_cyc  = 0;
      rp_vcyc = 0;
    end
    prev_rp    = bus_if.eq_read_ptr;
    prev_ptr   = bus_if.eq_read_ptr;
    prev_data  = bus_if.m_data;
    prev_last  = bus_if.m_last;
    prev_stall = bus_if.m_valid && !bus_if.m_ready;
  end

  // Sink: ready by default, optionally held low for 10 cycles on the third byte.
  initial begin
    bus_if.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && hs_idx == 2 && bus_if.m_valid && stall_cyc < 10) begin
        bus_if.m_ready = 1'b0;
        stall_cyc++;
      end else begin
        bus_if.m_ready = 1'b1;
      end
    end
  end

  task automatic start_burst(input bit stall);
    build_exp();
    hs_idx       = 0;
    tx_cnt       = 0;
    since_last   = -1;
    stall_en     = stall;
    stall_cyc    = 0;
    stall_checks = 0;
    chk_en       = 1'b1;
    @(posedge clk);
    #1 bus_if.eq_buff_full = 1'b1;
  endtask

  task automatic run_burst(input bit stall, input bit drop_mid);
    int cyc;
    start_burst(stall);
    cyc = 0;
    while (!bus_if.busy && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_rise", bus_if.busy, 1);
    cyc = 0;
    while (!bus_if.m_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_valid_latency", cyc, 20);
    if (drop_mid) begin
      repeat (200) @(negedge clk);
      bus_if.eq_buff_full = 1'b0;
    end
    cyc = 0;
    while (!bus_if.eq_tx_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("tx_done_seen", bus_if.eq_tx_done, 1);
    @(negedge clk);
    chk("byte_count", hs_idx, Nb);
    chk("tx_pulses", tx_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hold_viol;
    int tx_before;
    bus_if.eq_buff_full = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_read_ptr", bus_if.eq_read_ptr, 0);
    chk("rst_m_data", bus_if.m_data, 0);
    chk("rst_m_valid", bus_if.m_valid, 0);
    chk("rst_m_last", bus_if.m_last, 0);
    chk("rst_tx_done", bus_if.eq_tx_done, 0);
    chk("rst_busy", bus_if.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus_if.busy, 0);

    // Burst A: constant (+20, -20), stall on byte 3, buff_full kept high afterwards
    for (int i = 0; i < N; i++) mem[i] = 16'hEC14;
    run_burst(1'b1, 1'b0);
`ifdef DEMAP_16QAM_EN
    chk("const_first_byte", first_byte, 8'hEE);
`else
    chk("const_first_byte", first_byte, 8'hAA);
`endif
    chk("stall_hold_cycles", stall_checks, 10);
    hold_viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b1 || bus_if.m_valid !== 1'b0) hold_viol++;
    end
    chk("wait_clr_hold", hold_viol, 0);
    chk("wait_clr_no_retx", tx_cnt, 1);
    bus_if.eq_buff_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_clr_exit", bus_if.busy, 0);

    // Burst B: ramp {~ptr, ptr}, buff_full dropped mid-burst
    for (int i = 0; i < N; i++) mem[i] = {~8'(i), 8'(i)};
    build_exp();
`ifdef DEMAP_16QAM_EN
    chk("model_pin_ramp", exp_b[32], 8'h44);
`else
    chk("model_pin_ramp", exp_b[32], 8'h55);
`endif
    run_burst(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ramp_idle", bus_if.busy, 0);

    // Burst C: reset asserted while sample 100 is being fetched
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    start_burst(1'b0);
    cyc = 0;
    while (bus_if.eq_read_ptr != 8'd100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_ptr_100", bus_if.eq_read_ptr, 100);
    #2;
    chk_en    = 1'b0;
    tx_before = tx_any;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_read_ptr", bus_if.eq_read_ptr, 0);
    chk("mid_rst_m_data", bus_if.m_data, 0);
    chk("mid_rst_m_valid", bus_if.m_valid, 0);
    chk("mid_rst_m_last", bus_if.m_last, 0);
    chk("mid_rst_tx_done", bus_if.eq_tx_done, 0);
    chk("mid_rst_busy", bus_if.busy, 0);
    bus_if.eq_buff_full = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_tx_done", tx_any, tx_before);
    chk("post_rst_idle", bus_if.busy, 0);

    // Burst D: directed decision corner cases in the first byte, random remainder
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2780;  // re=-128, im=39
    mem[1] = 16'hD928;  // re=40,   im=-39
    mem[2] = 16'h0000;  // re=0,    im=0
    mem[3] = 16'hFFFF;  // re=-1,   im=-1
    build_exp();
    chk("model_pin_corner", exp_b[0], 8'hC9);
    run_burst(1'b0, 1'b0);
    chk("corner_first_byte", first_byte, 8'hC9);
    bus_if.eq_buff_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", bus_if.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
